// File: rtl/servo_pkg.sv
// ---------------------------------------------------------------------------
// servo_pkg
// Shared constants for the servo pulse-width path: value width, default PWM
// timing (50 MHz clock, 20 ms period) and the pulse-width codes produced by
// the angle decoder, so decoder and generator agree on the same numbers.
// ---------------------------------------------------------------------------
package servo_pkg;

    localparam int SERVO_W           = 20;
    localparam int SERVO_PERIOD      = 1000000;  // 20 ms at 50 MHz
    localparam int SERVO_MIN_WIDTH   = 10000;
    localparam int SERVO_MAX_WIDTH   = 100000;
    localparam int SERVO_RESET_WIDTH = 70000;    // the "no change" width
    localparam int SERVO_STEP        = 0;        // 0 = jump straight to target

    typedef logic [SERVO_W-1:0] servo_width_t;

    // Decoder output codes (pulse widths in clk cycles).
    localparam servo_width_t SERVO_LEFT     = 20'd62500;
    localparam servo_width_t SERVO_RIGHT    = 20'd10000;
    localparam servo_width_t SERVO_RELEASED = 20'd75000;
    localparam servo_width_t SERVO_HOLD     = 20'd70000;
    localparam servo_width_t SERVO_FIRE     = 20'd15000;
    localparam servo_width_t SERVO_RECOIL   = 20'd60000;

endpackage

// File: rtl/servo_pwm_gen_if.sv
// ---------------------------------------------------------------------------
// servo_pwm_gen_if
// Bundles the per-servo request and status signals.
//   value        : requested pulse width in cycles (master -> generator)
//   en           : output enable                    (master -> generator)
//   pwm_out      : registered servo PWM waveform    (generator -> master)
//   period_start : one-cycle pulse at counter 0     (generator -> master)
//   cur_width    : pulse width in effect this period(generator -> master)
//   ramping      : cur_width has not reached target (generator -> master)
// ---------------------------------------------------------------------------
interface servo_pwm_gen_if #(
    parameter int W = 20
);
    logic [W-1:0] value;
    logic         en;
    logic         pwm_out;
    logic         period_start;
    logic [W-1:0] cur_width;
    logic         ramping;

    modport master (
        output value,
        output en,
        input  pwm_out,
        input  period_start,
        input  cur_width,
        input  ramping
    );

    modport slave (
        input  value,
        input  en,
        output pwm_out,
        output period_start,
        output cur_width,
        output ramping
    );
endinterface

// File: rtl/servo_slew_limiter.sv
// ---------------------------------------------------------------------------
// servo_slew_limiter
// Combinational clamp of the requested width into [MIN_WIDTH, MAX_WIDTH] and
// one slew step of the current width toward that clamped target.
//   cur_i      : width in effect for the period now ending
//   value_i    : raw requested width
//   next_cur_o : width to use for the next period
//   target_o   : clamped request
// ---------------------------------------------------------------------------
module servo_slew_limiter #(
    parameter int W         = 20,
    parameter int MIN_WIDTH = 10000,
    parameter int MAX_WIDTH = 100000,
    parameter int STEP      = 0
) (
    input  logic [W-1:0] cur_i,
    input  logic [W-1:0] value_i,
    output logic [W-1:0] next_cur_o,
    output logic [W-1:0] target_o
);
    localparam logic [W-1:0] MIN_W  = W'(MIN_WIDTH);
    localparam logic [W-1:0] MAX_W  = W'(MAX_WIDTH);
    localparam logic [W-1:0] STEP_W = W'(STEP);

    always_comb begin
        target_o = value_i;
        if (value_i < MIN_W) begin
            target_o = MIN_W;
        end else if (value_i > MAX_W) begin
            target_o = MAX_W;
        end
    end

    generate
        if (STEP == 0) begin : gen_jump
            assign next_cur_o = target_o;
        end else begin : gen_slew
            // Direction is decided before subtracting so the difference can
            // never wrap in W bits.
            always_comb begin
                next_cur_o = target_o;
                if (target_o >= cur_i) begin
                    if ((target_o - cur_i) > STEP_W) begin
                        next_cur_o = cur_i + STEP_W;
                    end
                end else begin
                    if ((cur_i - target_o) > STEP_W) begin
                        next_cur_o = cur_i - STEP_W;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/servo_pwm_gen.sv
// ---------------------------------------------------------------------------
// servo_pwm_gen
// Free-running servo PWM generator. The requested width and enable are only
// sampled at the period boundary, so the waveform never contains runt or
// stretched pulses.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : servo_pwm_gen_if.slave (value/en in; pwm_out, period_start,
//         cur_width, ramping out)
// ---------------------------------------------------------------------------
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int W           = SERVO_W,
    parameter int PERIOD      = SERVO_PERIOD,
    parameter int MIN_WIDTH   = SERVO_MIN_WIDTH,
    parameter int MAX_WIDTH   = SERVO_MAX_WIDTH,
    parameter int STEP        = SERVO_STEP,
    parameter int RESET_WIDTH = SERVO_RESET_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    servo_pwm_gen_if.slave bus
);
    localparam logic [W-1:0] PERIOD_LAST = W'(PERIOD - 1);
    localparam logic [W-1:0] RESET_W     = W'(RESET_WIDTH);

    logic [W-1:0] cnt_q, cnt_d;
    logic         period_start_q;
    logic [W-1:0] cur_width_q, cur_width_d;
    logic [W-1:0] target_q, target_d;
    logic         en_lat_q, en_lat_d;
    logic         pwm_q, pwm_d;
    logic         ramping_q, ramping_d;
    logic         restart_q;
    logic         boundary;

    logic [W-1:0] slew_next;
    logic [W-1:0] slew_target;

    servo_slew_limiter #(
        .W         (W),
        .MIN_WIDTH (MIN_WIDTH),
        .MAX_WIDTH (MAX_WIDTH),
        .STEP      (STEP)
    ) u_slew (
        .cur_i      (cur_width_q),
        .value_i    (bus.value),
        .next_cur_o (slew_next),
        .target_o   (slew_target)
    );

    // A period begins on the wrap PERIOD-1 -> 0, and also on the first edge
    // after reset releases: restart_q holds the counter at 0 for that edge so
    // period_start appears the cycle after release, and the new period samples
    // value/en exactly like any other.
    assign boundary = restart_q || (cnt_q == PERIOD_LAST);

    always_comb begin
        cnt_d       = boundary ? '0 : cnt_q + W'(1);
        cur_width_d = cur_width_q;
        target_d    = target_q;
        en_lat_d    = en_lat_q;
        if (boundary) begin
            cur_width_d = slew_next;
            target_d    = slew_target;
            en_lat_d    = bus.en;
        end
        ramping_d = (cur_width_d != target_d);
        // Compare uses this cycle's count, so the pulse starts the cycle
        // after period_start and lasts exactly cur_width cycles.
        pwm_d     = en_lat_q && (cnt_q < cur_width_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            cur_width_q    <= RESET_W;
            target_q       <= RESET_W;
            en_lat_q       <= 1'b0;
            pwm_q          <= 1'b0;
            ramping_q      <= 1'b0;
            restart_q      <= 1'b1;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= boundary;
            cur_width_q    <= cur_width_d;
            target_q       <= target_d;
            en_lat_q       <= en_lat_d;
            pwm_q          <= pwm_d;
            ramping_q      <= ramping_d;
            restart_q      <= 1'b0;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = period_start_q;
    assign bus.cur_width    = cur_width_q;
    assign bus.ramping      = ramping_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_servo_pwm_gen
// Two generators side by side (STEP=0 and STEP=10) driven in lockstep with
// PERIOD=100, clamp 10..90, reset width 70. A per-period reference model
// predicts the pulse width in effect, the enable, and the ramping flag.
// ---------------------------------------------------------------------------
module tb_servo_pwm_gen;
    import servo_pkg::*;

    localparam int P    = 100;
    localparam int MINW = 10;
    localparam int MAXW = 90;
    localparam int RSTW = 70;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    servo_pwm_gen_if #(.W(20)) bus0 ();
    servo_pwm_gen_if #(.W(20)) bus1 ();

    servo_pwm_gen #(.W(20), .PERIOD(P), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW),
                    .STEP(0), .RESET_WIDTH(RSTW))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    servo_pwm_gen #(.W(20), .PERIOD(P), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW),
                    .STEP(10), .RESET_WIDTH(RSTW))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;

    // stimulus
    int   v[2];
    logic e;

    // reference model: width/target per instance, shared latched enable
    int   mcur[2];
    int   mtgt[2];
    logic men;
    int   step_of[2] = '{0, 10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
            $error("%s check failed", tag);
        end
    endtask

    task automatic apply();
        bus0.value = 20'(v[0]);
        bus1.value = 20'(v[1]);
        bus0.en    = e;
        bus1.en    = e;
    endtask

    function automatic int clampv(input int x);
        if (x < MINW) return MINW;
        if (x > MAXW) return MAXW;
        return x;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcur[d] = RSTW;
            mtgt[d] = RSTW;
        end
        men = 1'b0;
    endtask

    // What a new period should adopt, given the inputs present at its edge.
    task automatic model_boundary();
        for (int d = 0; d < 2; d++) begin
            int t;
            t = clampv(v[d]);
            if (step_of[d] == 0)
                mcur[d] = t;
            else if (t > mcur[d])
                mcur[d] = (mcur[d] + step_of[d] < t) ? mcur[d] + step_of[d] : t;
            else
                mcur[d] = (mcur[d] - step_of[d] > t) ? mcur[d] - step_of[d] : t;
            mtgt[d] = t;
        end
        men = e;
    endtask

    function automatic logic pwm_of(input int d);
        return (d == 0) ? bus0.pwm_out : bus1.pwm_out;
    endfunction

    task automatic check_status(input string tag);
        check({tag, "/d0/ps"},   32'(bus0.period_start), 32'd1);
        check({tag, "/d1/ps"},   32'(bus1.period_start), 32'd1);
        check({tag, "/d0/cur"},  32'(bus0.cur_width), 32'(mcur[0]));
        check({tag, "/d1/cur"},  32'(bus1.cur_width), 32'(mcur[1]));
        check({tag, "/d0/ramp"}, 32'(bus0.ramping), 32'(mcur[0] != mtgt[0]));
        check({tag, "/d1/ramp"}, 32'(bus1.ramping), 32'(mcur[1] != mtgt[1]));
    endtask

    // Entered at the negedge of a cnt==0 cycle; leaves at the next one.
    // Optionally changes value/en at the negedge where cnt==chg_at.
    task automatic run_period(input string tag, input int chg_at,
                              input int nv0, input int nv1, input logic nen);
        int   ew[2];
        logic een;
        int   hc[2];
        int   first[2];
        int   last[2];
        een = men;
        for (int d = 0; d < 2; d++) begin
            ew[d] = mcur[d]; hc[d] = 0; first[d] = 0; last[d] = 0;
        end
        for (int i = 1; i <= P; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (pwm_of(d) === 1'b1) begin
                    hc[d]++;
                    if (first[d] == 0) first[d] = i;
                    last[d] = i;
                end
            end
            if (i == chg_at) begin
                v[0] = nv0; v[1] = nv1; e = nen;
                apply();
            end
            if (i == P - 1) model_boundary();
        end
        for (int d = 0; d < 2; d++) begin
            int w;
            w = een ? ew[d] : 0;
            check($sformatf("%s/d%0d/high", tag, d),  32'(hc[d]),    32'(w));
            check($sformatf("%s/d%0d/first", tag, d), 32'(first[d]), 32'((w > 0) ? 1 : 0));
            check($sformatf("%s/d%0d/last", tag, d),  32'(last[d]),  32'(w));
        end
        check_status(tag);
        $display("period %-12s en=%0b w0=%0d w1=%0d next0=%0d next1=%0d",
                 tag, een, ew[0], ew[1], mcur[0], mcur[1]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] codes[6];
        int   hc[2];
        logic een;

        codes = '{SERVO_LEFT, SERVO_RIGHT, SERVO_RELEASED,
                  SERVO_HOLD, SERVO_FIRE, SERVO_RECOIL};

        // 1: reset state, then first period at 70
        v[0] = 70; v[1] = 70; e = 1'b1;
        apply();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        check("rst/d0/pwm",  32'(bus0.pwm_out), 32'd0);
        check("rst/d1/pwm",  32'(bus1.pwm_out), 32'd0);
        check("rst/d0/ps",   32'(bus0.period_start), 32'd0);
        check("rst/d0/cur",  32'(bus0.cur_width), 32'(RSTW));
        check("rst/d1/cur",  32'(bus1.cur_width), 32'(RSTW));
        check("rst/d0/ramp", 32'(bus0.ramping), 32'd0);
        rst = 1'b0;
        model_boundary();
        @(negedge clk);
        check_status("t1_start");
        run_period("t1", -1, 0, 0, 1'b1);

        // 2: mid-period change only takes effect next period
        run_period("t2_chg", 50, 30, 30, 1'b1);
        run_period("t2_after", -1, 0, 0, 1'b1);

        // 3: clamping at both ends
        run_period("t3_lo_set", 10, 5, 5, 1'b1);
        run_period("t3_lo", -1, 0, 0, 1'b1);
        run_period("t3_hi_set", 10, 200, 200, 1'b1);
        run_period("t3_hi", -1, 0, 0, 1'b1);

        // 4: slew 70 -> 30 in steps of 10 on the STEP instance
        run_period("t4_prep", 10, 70, 70, 1'b1);
        repeat (3) run_period("t4_settle", -1, 0, 0, 1'b1);
        run_period("t4_set", 10, 30, 30, 1'b1);
        repeat (5) run_period("t4_ramp", -1, 0, 0, 1'b1);

        // 5: enable changes wait for the boundary
        run_period("t5_prep", 10, 70, 70, 1'b1);
        repeat (3) run_period("t5_w70", -1, 0, 0, 1'b1);
        run_period("t5_drop", 20, 70, 70, 1'b0);
        run_period("t5_off", -1, 0, 0, 1'b0);
        run_period("t5_raise", 50, 70, 70, 1'b1);
        run_period("t5_on", -1, 0, 0, 1'b1);

        // 6: reset at cnt==40 in the middle of a pulse
        een = men;
        hc[0] = 0; hc[1] = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                if (pwm_of(d) === 1'b1) hc[d]++;
        end
        check("t6/d0/pre_high", 32'(hc[0]), 32'(een ? ((mcur[0] < 40) ? mcur[0] : 40) : 0));
        check("t6/d1/pre_high", 32'(hc[1]), 32'(een ? ((mcur[1] < 40) ? mcur[1] : 40) : 0));
        v[0] = 50; v[1] = 50;
        apply();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check("t6/d0/pwm",  32'(bus0.pwm_out), 32'd0);
        check("t6/d1/pwm",  32'(bus1.pwm_out), 32'd0);
        check("t6/d0/cur",  32'(bus0.cur_width), 32'(RSTW));
        check("t6/d1/ramp", 32'(bus1.ramping), 32'd0);
        $display("reset mid-period: pwm0=%0b cur0=%0d", bus0.pwm_out, bus0.cur_width);
        rst = 1'b0;
        model_boundary();
        @(negedge clk);
        check_status("t6_restart");
        run_period("t6_after", -1, 0, 0, 1'b1);
        run_period("t6_after2", -1, 0, 0, 1'b1);

        // 7: decoder code constants, clamped at this scale
        for (int k = 0; k < 6; k++)
            run_period($sformatf("t7_code%0d", k), 10, int'(codes[k]), int'(codes[k]), 1'b1);
        run_period("t7_last", 10, 40, 40, 1'b1);

        // 8: random values, enables and change points
        for (int k = 0; k < 40; k++) begin
            run_period($sformatf("rnd%0d", k), int'($urandom_range(1, P - 1)),
                       int'($urandom_range(0, 150)), int'($urandom_range(0, 150)),
                       logic'($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
